// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: raster position, window qualifier, kernel latch.
// Latency: counters/state update on the sampling edge; oWVAL trails the accepted pixel by LAT clocks.
// No backpressure: every iDVAL in ACTIVE is accepted; stray iDVAL in IDLE/DONE sets sticky oERR.
module conv_window_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int LAT    = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFVAL,
    input  logic       iDVAL,
    input  logic [1:0] iKSEL,
    input  logic       iKSEL_WR,
    output logic [1:0] oKSEL,
    output logic [9:0] oX,
    output logic [8:0] oY,
    output logic       oWVAL,
    output logic       oBUSY,
    output logic       oEOF,
    output logic       oERR
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

    state_t           state, state_nxt;
    logic             fval_q;
    logic             fval_rise;
    logic [1:0]       ksel_pend, ksel_pend_nxt;
    logic [9:0]       x_nxt;
    logic [8:0]       y_nxt;
    logic             err_set;
    logic             eof_nxt;
    logic             start;
    logic             win;
    logic [LAT-1:0]   wpipe;

    assign fval_rise     = iFVAL & ~fval_q;
    // A write in the same cycle as frame start must be the value that frame uses.
    assign ksel_pend_nxt = iKSEL_WR ? iKSEL : ksel_pend;
    assign win           = iDVAL && (state == ACTIVE) && (oX >= 10'd2) && (oY >= 9'd2);
    assign oWVAL         = wpipe[LAT-1];

    // Next-state, counter and event decode.
    always_comb begin
        state_nxt = state;
        x_nxt     = oX;
        y_nxt     = oY;
        err_set   = 1'b0;
        eof_nxt   = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (iDVAL) err_set = 1'b1;
                if (fval_rise) begin
                    state_nxt = ACTIVE;
                    x_nxt     = 10'd0;
                    y_nxt     = 9'd0;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (!iFVAL) begin
                    // Frame ended before its last pixel: short frame.
                    state_nxt = IDLE;
                    err_set   = 1'b1;
                end else if (iDVAL) begin
                    if (oX == X_LAST) begin
                        x_nxt = 10'd0;
                        if (oY == Y_LAST) begin
                            // Counters park at the origin once the frame is complete.
                            y_nxt     = 9'd0;
                            state_nxt = DONE;
                            eof_nxt   = 1'b1;
                        end else begin
                            y_nxt = oY + 9'd1;
                        end
                    end else begin
                        x_nxt = oX + 10'd1;
                    end
                end
            end
            DONE: begin
                if (iDVAL) err_set = 1'b1;
                if (!iFVAL) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, kernel registers and status outputs.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            fval_q    <= 1'b0;
            oX        <= 10'd0;
            oY        <= 9'd0;
            ksel_pend <= 2'd0;
            oKSEL     <= 2'd0;
            oBUSY     <= 1'b0;
            oEOF      <= 1'b0;
            oERR      <= 1'b0;
        end else begin
            state     <= state_nxt;
            fval_q    <= iFVAL;
            oX        <= x_nxt;
            oY        <= y_nxt;
            ksel_pend <= ksel_pend_nxt;
            if (start) oKSEL <= ksel_pend_nxt;
            oBUSY     <= (state_nxt == ACTIVE);
            oEOF      <= eof_nxt;
            if (err_set) oERR <= 1'b1;
        end
    end

    // Window-valid delay line, free-running like the datapath's valid pipeline.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            wpipe <= '0;
        end else begin
            wpipe[0] <= win;
            for (int i = 1; i < LAT; i++) wpipe[i] <= wpipe[i-1];
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
module tb_conv_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int L = 3;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iFVAL = 1'b0;
    logic       iDVAL = 1'b0;
    logic [1:0] iKSEL = 2'd0;
    logic       iKSEL_WR = 1'b0;
    logic [1:0] oKSEL;
    logic [9:0] oX;
    logic [8:0] oY;
    logic       oWVAL, oBUSY, oEOF, oERR;

    conv_window_ctrl #(.WIDTH(W), .HEIGHT(H), .LAT(L)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iKSEL(iKSEL), .iKSEL_WR(iKSEL_WR), .oKSEL(oKSEL),
        .oX(oX), .oY(oY), .oWVAL(oWVAL), .oBUSY(oBUSY), .oEOF(oEOF), .oERR(oERR)
    );

    always #5 iCLK = ~iCLK;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int mx = 0;
    int my = 0;
    int wcount = 0;
    int eofcount = 0;
    int wq[$];
    int eq[$];

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every oWVAL/oEOF pulse must match the cycle predicted when stimulus was driven.
    always @(negedge iCLK) begin
        if (oWVAL) begin
            wcount++;
            if (wq.size() == 0) check("wval_unexpected", 1, 0);
            else check("wval_cycle", cyc, wq.pop_front());
        end
        if (oEOF) begin
            eofcount++;
            if (eq.size() == 0) check("eof_unexpected", 1, 0);
            else check("eof_cycle", cyc, eq.pop_front());
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_frame(input logic wr, input logic [1:0] k);
        iFVAL    = 1'b1;
        iKSEL_WR = wr;
        iKSEL    = k;
        mx = 0;
        my = 0;
        wcount = 0;
        eofcount = 0;
        tick();
        iKSEL_WR = 1'b0;
        check("start_busy", oBUSY, 1);
        check("start_x", oX, 0);
        check("start_y", oY, 0);
    endtask

    task automatic pixel();
        iDVAL = 1'b1;
        check("px_x", oX, mx);
        check("px_y", oY, my);
        if (mx >= 2 && my >= 2) wq.push_back(cyc + L);
        if (mx == W - 1) begin
            mx = 0;
            if (my == H - 1) begin
                my = 0;
                eq.push_back(cyc + 1);
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
        tick();
        iDVAL = 1'b0;
    endtask

    task automatic end_frame();
        iFVAL = 1'b0;
        tick();
        idle(L + 2);
        check("end_busy", oBUSY, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        check("rst_x", oX, 0);
        check("rst_y", oY, 0);
        check("rst_ksel", oKSEL, 0);
        check("rst_wval", oWVAL, 0);
        check("rst_busy", oBUSY, 0);
        check("rst_eof", oEOF, 0);
        check("rst_err", oERR, 0);
        iRST = 1'b1;
        idle(2);

        // Frame 1: back-to-back pixels
        start_frame(1'b0, 2'd0);
        for (int i = 0; i < W * H; i++) pixel();
        idle(L + 1);
        check("f1_busy_done", oBUSY, 0);
        check("f1_x_park", oX, 0);
        check("f1_y_park", oY, 0);
        end_frame();
        check("f1_wcount", wcount, 2);
        check("f1_eofcount", eofcount, 1);
        check("f1_err", oERR, 0);

        // Frame 2: random gaps, kernel write mid-frame
        start_frame(1'b0, 2'd0);
        for (int i = 0; i < W * H; i++) begin
            if (i == 5) begin
                iKSEL = 2'd2;
                iKSEL_WR = 1'b1;
            end
            pixel();
            iKSEL_WR = 1'b0;
            check("f2_ksel_hold", oKSEL, 0);
            idle($urandom_range(1, 3));
        end
        idle(L + 1);
        end_frame();
        check("f2_wcount", wcount, 2);
        check("f2_eofcount", eofcount, 1);
        check("f2_ksel_after", oKSEL, 0);

        // Frame 3: pending kernel applied; stray iDVAL in DONE
        start_frame(1'b0, 2'd0);
        check("f3_ksel", oKSEL, 2);
        for (int i = 0; i < W * H; i++) pixel();
        check("f3_err_before", oERR, 0);
        iDVAL = 1'b1;
        tick();
        iDVAL = 1'b0;
        check("done_dval_err", oERR, 1);
        check("done_dval_x", oX, 0);
        check("done_dval_y", oY, 0);
        idle(L + 1);
        end_frame();
        check("f3_wcount", wcount, 2);

        // Reset, then stray iDVAL in IDLE
        iRST = 1'b0;
        #1;
        check("rst2_err", oERR, 0);
        tick();
        iRST = 1'b1;
        iDVAL = 1'b1;
        tick();
        iDVAL = 1'b0;
        check("idle_dval_err", oERR, 1);
        check("idle_dval_x", oX, 0);
        check("idle_dval_busy", oBUSY, 0);

        // Reset again; frame 4 with coincident kernel write, reset at pixel (1,1)
        iRST = 1'b0;
        tick();
        iRST = 1'b1;
        idle(1);
        start_frame(1'b1, 2'd1);
        check("f4_ksel_coincident", oKSEL, 1);
        for (int i = 0; i < W + 1; i++) pixel();
        check("f4_at_x", oX, 1);
        check("f4_at_y", oY, 1);
        iRST = 1'b0;
        iFVAL = 1'b0;
        #1;
        check("arst_x", oX, 0);
        check("arst_y", oY, 0);
        check("arst_ksel", oKSEL, 0);
        check("arst_busy", oBUSY, 0);
        check("arst_err", oERR, 0);
        wq.delete();
        eq.delete();
        tick();
        iRST = 1'b1;
        idle(1);

        // Frame 5: short frame after 7 pixels
        start_frame(1'b0, 2'd0);
        check("f5_err_start", oERR, 0);
        for (int i = 0; i < 7; i++) pixel();
        end_frame();
        check("short_err", oERR, 1);
        check("short_eof", eofcount, 0);

        // Frame 6: full frame completes, error stays sticky
        start_frame(1'b0, 2'd0);
        for (int i = 0; i < W * H; i++) pixel();
        idle(L + 1);
        end_frame();
        check("f6_wcount", wcount, 2);
        check("f6_eofcount", eofcount, 1);
        check("f6_err_sticky", oERR, 1);

        check("wq_left", wq.size(), 0);
        check("eq_left", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
